// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//
// Word-addressed 32-bit memory target for the processor datapath's memory
// port. It speaks a four-phase req/ack handshake and inserts a programmable
// number of wait states between accepting a request and acknowledging it.
//
// Parameters
//   ADDR_BITS    word-address bits; storage depth is 2**ADDR_BITS words.
//                Must be less than 32.
//   WAIT_STATES  extra clocks between accept and acknowledge (0..15).
//
// Ports
//   iClk    in   1   rising-edge clock
//   iRst    in   1   synchronous active-high reset (storage contents kept)
//   iReq    in   1   request, held by the initiator until oAck is seen
//   iWrite  in   1   1 = store, 0 = load (sampled at accept)
//   iAddr   in   32  word address (sampled at accept)
//   iData   in   32  store data (sampled at accept)
//   oData   out  32  load data, held until the next load completes
//   oAck    out  1   high from completion until iReq is seen low
//   oBusy   out  1   high while a request is in progress or acknowledged
//   oErr    out  1   high with oAck when the captured address was out of range
// ----------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iReq,
    input  logic        iWrite,
    input  logic [31:0] iAddr,
    input  logic [31:0] iData,
    output logic [31:0] oData,
    output logic        oAck,
    output logic        oBusy,
    output logic        oErr
);

    localparam int          DEPTH     = 2 ** ADDR_BITS;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [3:0]             cnt_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [31:0]            wdata_q;
    logic                   write_q;
    logic                   oor_q;     // captured address was out of range
    logic [31:0]            rdata_q;
    logic                   ack_q;
    logic                   busy_q;
    logic                   err_q;

    // Storage: no reset so that it maps onto block RAM and survives iRst.
    logic [31:0]            mem [DEPTH];

    logic                   addr_oor;
    logic                   do_access;
    logic                   mem_we;

    // Any set bit above the implemented word address is out of range.
    assign addr_oor  = |iAddr[31:ADDR_BITS];

    // The access happens on the edge where the wait counter has run out.
    assign do_access = (state_q == BUSY) && (cnt_q == 4'd0);

    // iRst on the commit edge aborts the store as well as the handshake.
    assign mem_we    = !iRst && do_access && write_q && !oor_q;

    always_ff @(posedge iClk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    // Handshake state machine; all outputs are registered here.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            write_q <= 1'b0;
            oor_q   <= 1'b0;
            rdata_q <= 32'd0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iReq) begin
                        addr_q  <= iAddr[ADDR_BITS-1:0];
                        wdata_q <= iData;
                        write_q <= iWrite;
                        oor_q   <= addr_oor;
                        cnt_q   <= WAIT_INIT;
                        state_q <= BUSY;
                        busy_q  <= 1'b1;
                    end
                end

                BUSY: begin
                    // iReq is deliberately ignored here: a dropped request
                    // still completes so the initiator sees a clean ack.
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (!write_q) begin
                            rdata_q <= oor_q ? 32'd0 : mem[addr_q];
                        end
                        ack_q   <= 1'b1;
                        err_q   <= oor_q;
                        state_q <= ACK;
                    end
                end

                ACK: begin
                    // Leaving through IDLE guarantees one idle cycle before
                    // the next accept, so a held iReq never re-triggers.
                    if (!iReq) begin
                        ack_q   <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign oData = rdata_q;
    assign oAck  = ack_q;
    assign oBusy = busy_q;
    assign oErr  = err_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed memory target that serves the processor datapath's memory port. It captures the requested address, store data and read/write command, and returns read data or commits the store.
- Uses a four-phase req/ack handshake with a programmable number of wait states, so the control unit can be exercised against realistic memory latency.
- Sits between the datapath (memory address, store data, load data) and the instruction/data storage.

Parameters:
- ADDR_BITS, 10, number of word-address bits; storage depth = 2**ADDR_BITS words of 32 bits.
- WAIT_STATES, 2, extra clocks between request accept and acknowledge (0 allowed, max 15).

Ports:
- iClk  input  1  rising-edge clock.
- iRst  input  1  synchronous active-high reset.
- iReq  input  1  request; held high by the initiator until oAck is seen, then dropped.
- iWrite  input  1  1 = store, 0 = load; sampled at accept.
- iAddr  input  32  word address; sampled at accept.
- iData  input  32  store data; sampled at accept.
- oData  output  32  load data; valid while oAck=1, held until the next read completes.
- oAck  output  1  acknowledge; high from completion until iReq is low.
- oBusy  output  1  high in BUSY and ACK states.
- oErr  output  1  high with oAck when the captured address was out of range.

Behaviour:
- Reset (synchronous, iRst=1 at a rising edge):
  - state=IDLE; oAck=0, oBusy=0, oErr=0, oData=0, wait counter=0.
  - Captured address/data/command registers are cleared.
  - The storage array is NOT cleared; its contents are retained across reset.
  - iRst has priority over every other input.
- State machine, with transitions on the rising edge:
  - IDLE: if iReq=1, capture iAddr/iData/iWrite, load counter=WAIT_STATES, go to BUSY (the "accept edge"). Otherwise stay.
  - BUSY: if counter≠0, decrement. If counter==0, perform the access and go to ACK:
    - Store: array[addr]<=data.
    - Load: oData<=array[addr].
    - Set oAck=1 and oErr=range flag.
  - ACK: hold oAck, oData and oErr. When iReq=0, go to IDLE and clear oAck and oErr. oData keeps its last value.
- Latency: oAck rises exactly WAIT_STATES+1 clock edges after the accept edge. With WAIT_STATES=0 it rises on the edge following accept.
- Range check:
  - The captured address is out of range if any bit of iAddr[31:ADDR_BITS] is set.
  - Out-of-range store: discarded; array unchanged.
  - Out-of-range load: oData<=0.
  - In both cases oErr=1 with oAck, and the handshake completes normally.
- Inputs are ignored outside the accept edge:
  - iAddr/iData/iWrite changing during BUSY or ACK has no effect.
  - iReq dropped during BUSY does not abort the access; the access completes, and ACK exits on the first edge where iReq=0, so oAck is high for ≥1 cycle.
- Back-to-back: a new request is accepted only in IDLE. Minimum one idle cycle between the oAck fall and the next accept. iReq held high continuously after oAck never causes a second access.
- Reset mid-operation: iRst in BUSY aborts the access. A pending store is not committed, and oAck never rises for that request.
- oBusy = (state≠IDLE), registered alongside the state.
- Store followed by load of the same address returns the new value; there is no read-during-write hazard because accesses are serialized.

Test Plan:
1. Reset, WAIT_STATES=2: store 0xDEADBEEF to addr 0x005 → oAck rises 3 edges after accept, oErr=0. Drop iReq → oAck falls next edge. Load 0x005 → oData=0xDEADBEEF with oAck.
2. WAIT_STATES=0: store 0x12345678 to 0x3FF, then load 0x3FF → each oAck rises 1 edge after accept; oData=0x12345678.
3. Store 0xAAAA5555 to 0x00000400 (out of range, ADDR_BITS=10) → oAck=1 with oErr=1. Then load 0x000 → previously written 0x00000000 is unchanged. Load 0x400 → oData=0, oErr=1.
4. Hold iReq high for 10 cycles after oAck on a store to 0x010 (data 0x1) → exactly one access; oAck stays high until iReq drops. Then a second request with data 0x2 → load 0x010 returns 0x2.
5. Store 0xCAFEF00D to 0x020 and assert iRst one cycle after accept → oAck never rises, oBusy=0 and state IDLE after reset. Load 0x020 → the value present before the aborted store, not 0xCAFEF00D.
6. Accept a load of 0x005, then change iAddr to 0x006 and drop iReq during BUSY → oData holds array[0x005]; oAck is high for exactly one cycle; oBusy falls with oAck.
